// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one word_to_byte_tx serializer between two requesters,
// with a timeout watchdog on each transfer and a guard gap between transfers.
module uart_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        sys_clk,
  input  logic        sw_0,
  input  logic [1:0]  i_req_valid,
  input  logic [1:0]  i_req_mode,
  input  logic [63:0] i_req_word,
  input  logic [15:0] i_req_byte,
  output logic [1:0]  o_req_grant,
  output logic [1:0]  o_req_done,
  output logic [1:0]  o_req_err,
  output logic        o_tx_enable,
  output logic        o_tx_mode_select,
  output logic [31:0] o_tx_word,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          owner, owner_d;
  logic          last_owner, last_owner_d;
  logic [TW-1:0] timer, timer_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          winner;
  logic          en_d, mode_d;
  logic [31:0]   word_d;
  logic [7:0]    byte_d;
  logic [1:0]    grant_d, done_d, err_d;

  always_ff @(posedge sys_clk or posedge sw_0) begin
    if (sw_0) begin
      state            <= S_IDLE;
      owner            <= 1'b0;
      last_owner       <= 1'b1;
      timer            <= '0;
      gap_cnt          <= '0;
      o_tx_enable      <= 1'b0;
      o_tx_mode_select <= 1'b0;
      o_tx_word        <= '0;
      o_tx_byte        <= '0;
      o_req_grant      <= '0;
      o_req_done       <= '0;
      o_req_err        <= '0;
    end else begin
      state            <= state_d;
      owner            <= owner_d;
      last_owner       <= last_owner_d;
      timer            <= timer_d;
      gap_cnt          <= gap_cnt_d;
      o_tx_enable      <= en_d;
      o_tx_mode_select <= mode_d;
      o_tx_word        <= word_d;
      o_tx_byte        <= byte_d;
      o_req_grant      <= grant_d;
      o_req_done       <= done_d;
      o_req_err        <= err_d;
    end
  end

  // On a tie the requester that did not win last time is served.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    timer_d      = timer;
    gap_cnt_d    = gap_cnt;
    en_d         = o_tx_enable;
    mode_d       = o_tx_mode_select;
    word_d       = o_tx_word;
    byte_d       = o_tx_byte;
    grant_d      = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    winner       = (i_req_valid == 2'b11) ? ~last_owner : i_req_valid[1];

    case (state)
      S_IDLE: begin
        if (i_req_valid != 2'b00) begin
          mode_d       = i_req_mode[winner];
          word_d       = winner ? i_req_word[63:32] : i_req_word[31:0];
          byte_d       = winner ? i_req_byte[15:8] : i_req_byte[7:0];
          en_d         = 1'b1;
          grant_d      = winner ? 2'b10 : 2'b01;
          owner_d      = winner;
          last_owner_d = winner;
          timer_d      = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_tx_done) begin
          en_d      = 1'b0;
          done_d    = owner ? 2'b10 : 2'b01;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else if (timer == TIMER_LAST) begin
          en_d      = 1'b0;
          err_d     = owner ? 2'b10 : 2'b01;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized
// transfers compared against a round-robin reference model.
module tb_uart_tx_scheduler;
  localparam int TO  = 100;
  localparam int GAP = 2;

  logic        sys_clk = 1'b0;
  logic        sw_0;
  logic [1:0]  i_req_valid, i_req_mode;
  logic [63:0] i_req_word;
  logic [15:0] i_req_byte;
  logic        i_tx_done;
  logic [1:0]  o_req_grant, o_req_done, o_req_err;
  logic        o_tx_enable, o_tx_mode_select, o_busy;
  logic [31:0] o_tx_word;
  logic [7:0]  o_tx_byte;

  int n_pass  = 0;
  int n_total = 0;
  int model_last;

  uart_tx_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .sw_0(sw_0),
    .i_req_valid(i_req_valid), .i_req_mode(i_req_mode),
    .i_req_word(i_req_word), .i_req_byte(i_req_byte),
    .o_req_grant(o_req_grant), .o_req_done(o_req_done), .o_req_err(o_req_err),
    .o_tx_enable(o_tx_enable), .o_tx_mode_select(o_tx_mode_select),
    .o_tx_word(o_tx_word), .o_tx_byte(o_tx_byte),
    .i_tx_done(i_tx_done), .o_busy(o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference arbitration rule: a lone requester wins, a tie goes to the other one.
  function automatic int pick_winner(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return (v == 2'b10) ? 1 : 0;
  endfunction

  task automatic do_reset;
    sw_0 = 1'b1;
    i_req_valid = 2'b00; i_req_mode = 2'b00; i_req_word = '0; i_req_byte = '0; i_tx_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    sw_0 = 1'b0;
    model_last = 1;
    @(negedge sys_clk);
  endtask

  task automatic wait_grant(output int low, output bit ok);
    low = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (o_req_grant != 2'b00) begin
        ok = 1'b1;
        break;
      end
      if (!o_tx_enable) low++;
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    sw_0 = 1'b1;
    #2;
    n_total++; if (o_tx_enable !== 1'b0) $display("[TB] FAIL reset_enable got %b want 0", o_tx_enable); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", o_busy); else n_pass++;
    n_total++; if ({o_req_grant, o_req_done, o_req_err} !== 6'b0) $display("[TB] FAIL reset_pulses got %b want 0", {o_req_grant, o_req_done, o_req_err}); else n_pass++;
    n_total++; if ({o_tx_mode_select, o_tx_word, o_tx_byte} !== 41'b0) $display("[TB] FAIL reset_data got %h want 0", {o_tx_mode_select, o_tx_word, o_tx_byte}); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_byte;
    int low; bit ok;
    do_reset();
    i_req_valid = 2'b01; i_req_mode = 2'b00; i_req_byte = 16'h00AB;
    wait_grant(low, ok);
    n_total++; if (!ok || low != 0) $display("[TB] FAIL single_grant_latency got ok=%0d low=%0d want ok=1 low=0", ok, low); else n_pass++;
    n_total++; if (o_req_grant !== 2'b01) $display("[TB] FAIL single_grant got %b want 01", o_req_grant); else n_pass++;
    n_total++; if (o_tx_byte !== 8'hAB || o_tx_mode_select !== 1'b0 || o_tx_enable !== 1'b1) $display("[TB] FAIL single_latch got byte=%h mode=%b en=%b want AB 0 1", o_tx_byte, o_tx_mode_select, o_tx_enable); else n_pass++;
    i_req_valid = 2'b00;
    repeat (5) @(negedge sys_clk);
    n_total++; if (o_tx_enable !== 1'b1 || o_req_grant !== 2'b00) $display("[TB] FAIL single_hold got en=%b grant=%b want 1 00", o_tx_enable, o_req_grant); else n_pass++;
    i_tx_done = 1'b1;
    @(negedge sys_clk);
    i_tx_done = 1'b0;
    n_total++; if (o_req_done !== 2'b01 || o_tx_enable !== 1'b0) $display("[TB] FAIL single_done got done=%b en=%b want 01 0", o_req_done, o_tx_enable); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_req_done !== 2'b00 || o_busy !== 1'b1) $display("[TB] FAIL single_done_pulse got done=%b busy=%b want 00 1", o_req_done, o_busy); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_busy !== 1'b0) $display("[TB] FAIL single_idle got busy=%b want 0", o_busy); else n_pass++;
    model_last = 0;
  endtask

  task automatic test_round_robin;
    int low, exp_w, d; bit ok;
    do_reset();
    i_req_byte = 16'h0010; i_req_word = {32'h00FF12CD, 32'h0}; i_req_mode = 2'b10;
    i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(low, ok);
      exp_w = pick_winner(2'b11, model_last);
      n_total++; if (!ok) $display("[TB] FAIL rr_grant_timeout got none want grant %0d", k);
      else if (o_req_grant !== (exp_w ? 2'b10 : 2'b01)) $display("[TB] FAIL rr_order got %b want req%0d", o_req_grant, exp_w);
      else n_pass++;
      if (exp_w == 1) begin
        n_total++; if (o_tx_word !== 32'h00FF12CD || o_tx_mode_select !== 1'b1) $display("[TB] FAIL rr_word got %h/%b want 00ff12cd/1", o_tx_word, o_tx_mode_select); else n_pass++;
      end else begin
        n_total++; if (o_tx_byte !== 8'h10 || o_tx_mode_select !== 1'b0) $display("[TB] FAIL rr_byte got %h/%b want 10/0", o_tx_byte, o_tx_mode_select); else n_pass++;
      end
      if (k > 0) begin
        n_total++; if (low + 1 != GAP + 1) $display("[TB] FAIL rr_gap got %0d low cycles want %0d", low + 1, GAP + 1); else n_pass++;
      end
      model_last = exp_w;
      d = $urandom_range(0, 4);
      repeat (d) @(negedge sys_clk);
      i_tx_done = 1'b1;
      @(negedge sys_clk);
      i_tx_done = 1'b0;
      n_total++; if (o_req_done !== (exp_w ? 2'b10 : 2'b01) || o_tx_enable !== 1'b0) $display("[TB] FAIL rr_done got %b en=%b want req%0d", o_req_done, o_tx_enable, exp_w); else n_pass++;
    end
    i_req_valid = 2'b00;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_timeout;
    int low, hi; bit ok;
    do_reset();
    i_req_valid = 2'b10; i_req_mode = 2'b10; i_req_word = {$urandom, $urandom};
    wait_grant(low, ok);
    n_total++; if (!ok || o_req_grant !== 2'b10) $display("[TB] FAIL to_grant got %b want 10", o_req_grant); else n_pass++;
    i_req_valid = 2'b00;
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (o_tx_enable) hi++;
      else break;
    end
    n_total++; if (hi != TO) $display("[TB] FAIL to_enable_cycles got %0d want %0d", hi, TO); else n_pass++;
    n_total++; if (o_req_err !== 2'b10 || o_req_done !== 2'b00) $display("[TB] FAIL to_err got err=%b done=%b want 10 00", o_req_err, o_req_done); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_req_err !== 2'b00 || o_busy !== 1'b1) $display("[TB] FAIL to_err_pulse got err=%b busy=%b want 00 1", o_req_err, o_busy); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_busy !== 1'b0) $display("[TB] FAIL to_idle got busy=%b want 0", o_busy); else n_pass++;
    model_last = 1;
  endtask

  task automatic test_collision;
    int low; bit ok;
    do_reset();
    i_req_valid = 2'b01; i_req_byte = 16'h0033;
    wait_grant(low, ok);
    i_req_valid = 2'b00;
    repeat (TO - 1) @(negedge sys_clk);
    n_total++; if (o_tx_enable !== 1'b1) $display("[TB] FAIL coll_still_busy got en=%b want 1", o_tx_enable); else n_pass++;
    i_tx_done = 1'b1;
    @(negedge sys_clk);
    i_tx_done = 1'b0;
    n_total++; if (o_req_done !== 2'b01 || o_req_err !== 2'b00) $display("[TB] FAIL coll_done_wins got done=%b err=%b want 01 00", o_req_done, o_req_err); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_req_err !== 2'b00) $display("[TB] FAIL coll_late_err got %b want 00", o_req_err); else n_pass++;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid;
    int low; bit ok;
    do_reset();
    i_req_valid = 2'b01; i_req_byte = 16'h7766;
    wait_grant(low, ok);
    i_req_valid = 2'b00;
    repeat (20) @(negedge sys_clk);
    #2 sw_0 = 1'b1;
    #1;
    n_total++; if (o_tx_enable !== 1'b0 || o_busy !== 1'b0 || o_tx_byte !== 8'h00) $display("[TB] FAIL rstmid_async got en=%b busy=%b byte=%h want 0 0 00", o_tx_enable, o_busy, o_tx_byte); else n_pass++;
    n_total++; if ({o_req_grant, o_req_done, o_req_err} !== 6'b0) $display("[TB] FAIL rstmid_pulses got %b want 0", {o_req_grant, o_req_done, o_req_err}); else n_pass++;
    @(negedge sys_clk);
    sw_0 = 1'b0;
    model_last = 1;
    i_req_valid = 2'b11; i_req_byte = 16'h2211; i_req_mode = 2'b00;
    wait_grant(low, ok);
    n_total++; if (!ok || o_req_grant !== 2'b01 || low != 0) $display("[TB] FAIL rstmid_first_tie got %b low=%0d want 01 0", o_req_grant, low); else n_pass++;
    i_req_valid = 2'b00;
    i_tx_done = 1'b1;
    @(negedge sys_clk);
    i_tx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    model_last = 0;
  endtask

  task automatic test_isolation;
    int low; bit ok;
    do_reset();
    i_req_valid = 2'b01; i_req_mode = 2'b00; i_req_byte = 16'h005A;
    wait_grant(low, ok);
    i_req_valid = 2'b00; i_req_byte[7:0] = 8'h01; i_req_mode = 2'b11;
    repeat (3) @(negedge sys_clk);
    n_total++; if (o_tx_byte !== 8'h5A || o_tx_mode_select !== 1'b0) $display("[TB] FAIL iso_frozen got %h/%b want 5a/0", o_tx_byte, o_tx_mode_select); else n_pass++;
    i_tx_done = 1'b1;
    @(negedge sys_clk);
    i_tx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_total++; if (o_busy !== 1'b0) $display("[TB] FAIL iso_idle got busy=%b want 0", o_busy); else n_pass++;
    i_tx_done = 1'b1;
    @(negedge sys_clk);
    i_tx_done = 1'b0;
    n_total++; if ({o_req_grant, o_req_done, o_req_err} !== 6'b0 || o_busy !== 1'b0 || o_tx_enable !== 1'b0) $display("[TB] FAIL iso_spurious_done got pulses=%b busy=%b en=%b want 0 0 0", {o_req_grant, o_req_done, o_req_err}, o_busy, o_tx_enable); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (o_busy !== 1'b0 || o_tx_byte !== 8'h5A) $display("[TB] FAIL iso_no_change got busy=%b byte=%h want 0 5a", o_busy, o_tx_byte); else n_pass++;
  endtask

  task automatic test_random;
    int low, exp_w, d, hi; bit ok;
    logic [1:0] v, m;
    logic [63:0] w;
    logic [15:0] b;
    logic [31:0] exp_word;
    logic [7:0] exp_byte;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      v = 2'($urandom_range(1, 3)); m = 2'($urandom); w = {$urandom, $urandom}; b = 16'($urandom);
      i_req_valid = v; i_req_mode = m; i_req_word = w; i_req_byte = b;
      exp_w    = pick_winner(v, model_last);
      exp_word = exp_w ? w[63:32] : w[31:0];
      exp_byte = exp_w ? b[15:8] : b[7:0];
      wait_grant(low, ok);
      n_total++; if (!ok || o_req_grant !== (exp_w ? 2'b10 : 2'b01)) $display("[TB] FAIL rnd_grant got %b want req%0d (valid %b)", o_req_grant, exp_w, v); else n_pass++;
      if (k > 0) begin
        n_total++; if (low + 1 != GAP + 1) $display("[TB] FAIL rnd_gap got %0d want %0d", low + 1, GAP + 1); else n_pass++;
      end
      n_total++; if (o_tx_word !== exp_word || o_tx_byte !== exp_byte || o_tx_mode_select !== m[exp_w]) $display("[TB] FAIL rnd_latch got %h/%h/%b want %h/%h/%b", o_tx_word, o_tx_byte, o_tx_mode_select, exp_word, exp_byte, m[exp_w]); else n_pass++;
      model_last = exp_w;
      i_req_valid = 2'b00; i_req_word = {$urandom, $urandom}; i_req_byte = 16'($urandom); i_req_mode = 2'($urandom);
      d = $urandom_range(0, 6);
      hi = 1;
      for (int i = 0; i < d; i++) begin
        @(negedge sys_clk);
        if (o_tx_enable) hi++;
      end
      n_total++; if (hi != d + 1) $display("[TB] FAIL rnd_enable_cycles got %0d want %0d", hi, d + 1); else n_pass++;
      i_tx_done = 1'b1;
      @(negedge sys_clk);
      i_tx_done = 1'b0;
      n_total++; if (o_req_done !== (exp_w ? 2'b10 : 2'b01) || o_tx_enable !== 1'b0 || o_tx_word !== exp_word) $display("[TB] FAIL rnd_done got done=%b en=%b word=%h want req%0d 0 %h", o_req_done, o_tx_enable, o_tx_word, exp_w, exp_word); else n_pass++;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    sw_0 = 1'b1;
    i_req_valid = 2'b00; i_req_mode = 2'b00; i_req_word = '0; i_req_byte = '0; i_tx_done = 1'b0;
    model_last = 1;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_isolation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish before 500000");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
